// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers: shift-add multiply and
// restoring divide over WIDTH cycles, with sign fix-up in a final cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             WriteHi,
   input  logic             WriteLo,
   input  logic [WIDTH-1:0] WriteData,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

   state_t state, state_next;

   logic [CNT_W-1:0] cnt;

   // Operation context captured when Start is accepted
   logic             op_div;
   logic             neg_res;
   logic             neg_rem;
   logic             dbz;
   logic [WIDTH-1:0] a_raw;
   logic [WIDTH-1:0] mcand;

   // Multiply: {hi_acc, lo_acc} is the partial product with the multiplier in lo_acc.
   // Divide: hi_acc is the partial remainder, lo_acc shifts dividend out / quotient in.
   logic [WIDTH-1:0] hi_acc;
   logic [WIDTH-1:0] lo_acc;

   logic             is_signed;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;
   logic [2*WIDTH-1:0] prod_fixed;
   logic [WIDTH-1:0] quo_fixed;
   logic [WIDTH-1:0] rem_fixed;

   function automatic logic [2*WIDTH-1:0] fix_product(input logic [2*WIDTH-1:0] p,
                                                       input logic neg);
      return neg ? -p : p;
   endfunction

   function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] v,
                                                 input logic neg);
      return neg ? -v : v;
   endfunction

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (Start) state_next = RUN;
         RUN:     if (cnt == LAST_ITER) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      is_signed = ~Op[0];
      a_mag     = (is_signed && A[WIDTH-1]) ? -A : A;
      b_mag     = (is_signed && B[WIDTH-1]) ? -B : B;

      mul_sum   = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, mcand} : '0);

      div_shift = {hi_acc, lo_acc[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, mcand});
      div_diff  = WIDTH'(div_shift - {1'b0, mcand});

      prod_fixed = fix_product({hi_acc, lo_acc}, neg_res);
      quo_fixed  = fix_sign(lo_acc, neg_res);
      rem_fixed  = fix_sign(hi_acc, neg_rem);
   end

   // Control and architectural registers
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         Hi        <= '0;
         Lo        <= '0;
      end else begin
         state <= state_next;
         Busy  <= (state_next != IDLE);
         Done  <= (state == FIX);
         unique case (state)
            IDLE: begin
               if (Start) begin
                  cnt       <= '0;
                  DivByZero <= 1'b0;
               end else begin
                  if (WriteHi) Hi <= WriteData;
                  if (WriteLo) Lo <= WriteData;
               end
            end
            RUN: cnt <= cnt + CNT_W'(1);
            FIX: begin
               DivByZero <= dbz;
               if (!op_div) begin
                  Hi <= prod_fixed[2*WIDTH-1:WIDTH];
                  Lo <= prod_fixed[WIDTH-1:0];
               end else if (dbz) begin
                  Hi <= a_raw;
                  Lo <= '1;
               end else begin
                  Hi <= rem_fixed;
                  Lo <= quo_fixed;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath: operand capture and one iteration per RUN cycle
   always_ff @(posedge Clock) begin
      if (state == IDLE && Start) begin
         op_div  <= Op[1];
         neg_res <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
         neg_rem <= is_signed & A[WIDTH-1];
         dbz     <= Op[1] & (B == '0);
         a_raw   <= A;
         hi_acc  <= '0;
         if (Op[1]) begin
            lo_acc <= a_mag;
            mcand  <= b_mag;
         end else begin
            lo_acc <= b_mag;
            mcand  <= a_mag;
         end
      end else if (state == RUN) begin
         if (!op_div) begin
            hi_acc <= mul_sum[WIDTH:1];
            lo_acc <= {mul_sum[0], lo_acc[WIDTH-1:1]};
         end else if (div_ge) begin
            hi_acc <= div_diff;
            lo_acc <= {lo_acc[WIDTH-2:0], 1'b1};
         end else begin
            hi_acc <= div_shift[WIDTH-1:0];
            lo_acc <= {lo_acc[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        Start = 1'b0;
   logic [1:0]  Op = 2'b00;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        WriteHi = 1'b0;
   logic        WriteLo = 1'b0;
   logic [31:0] WriteData = '0;
   logic        Busy;
   logic        Done;
   logic        DivByZero;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   muldiv_unit #(.WIDTH(32)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .WriteHi(WriteHi), .WriteLo(WriteLo), .WriteData(WriteData),
      .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
   );

   always #5 Clock = ~Clock;

   // Called 1 time unit after an edge; returns after the edge where Busy drops.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles, output logic done_seen);
      Start = 1'b1; Op = op; A = a; B = b;
      @(posedge Clock); #1;
      Start = 1'b0; A = $urandom; B = $urandom;
      busy_cycles = 0;
      while (Busy === 1'b1 && busy_cycles < 100) begin
         busy_cycles++;
         @(posedge Clock); #1;
      end
      done_seen = Done;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      checks++; if ({Busy, Done, DivByZero} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want 000", {Busy, Done, DivByZero}); end
      checks++; if ({Hi, Lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h want 0", {Hi, Lo}); end
      Reset = 1'b1;
      @(posedge Clock); #1;
   endtask

   task automatic test_multu();
      int bc; logic dn;
      do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dn);
      checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy got %0d want 33", bc); end
      checks++; if (dn !== 1'b1) begin errors++; $display("FAIL multu_done got %b want 1", dn); end
      checks++; if ({Hi, Lo} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_res got %h want FFFFFFFE00000001", {Hi, Lo}); end
      checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL multu_dbz got %b want 0", DivByZero); end
      @(posedge Clock); #1;
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", Done); end
      checks++; if ({Hi, Lo} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL hilo_hold got %h want FFFFFFFE00000001", {Hi, Lo}); end
   endtask

   task automatic test_mult();
      int bc; logic dn;
      do_op(MULT, 32'hFFFFFFFD, 32'h00000005, bc, dn);
      checks++; if ({dn, Hi, Lo} !== {1'b1, 64'hFFFFFFFF_FFFFFFF1}) begin errors++; $display("FAIL mult_neg got done=%b %h want done=1 FFFFFFFFFFFFFFF1", dn, {Hi, Lo}); end
      do_op(MULT, 32'h80000000, 32'h80000000, bc, dn);
      checks++; if ({dn, Hi, Lo} !== {1'b1, 64'h40000000_00000000}) begin errors++; $display("FAIL mult_min got done=%b %h want done=1 4000000000000000", dn, {Hi, Lo}); end
   endtask

   task automatic test_div();
      int bc; logic dn;
      do_op(DIV, 32'hFFFFFFF9, 32'h00000002, bc, dn);
      checks++; if ({Hi, Lo} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg got Hi:Lo=%h want FFFFFFFFFFFFFFFD", {Hi, Lo}); end
      checks++; if (bc !== 33) begin errors++; $display("FAIL div_busy got %0d want 33", bc); end
      do_op(DIV, 32'h00000007, 32'hFFFFFFFE, bc, dn);
      checks++; if ({Hi, Lo} !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL div_negdivisor got Hi:Lo=%h want 00000001FFFFFFFD", {Hi, Lo}); end
      do_op(DIV, 32'h80000000, 32'hFFFFFFFF, bc, dn);
      checks++; if ({Hi, Lo} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_minwrap got Hi:Lo=%h want 0000000080000000", {Hi, Lo}); end
      do_op(DIVU, 32'h00000064, 32'h00000007, bc, dn);
      checks++; if ({dn, Hi, Lo} !== {1'b1, 64'h00000002_0000000E}) begin errors++; $display("FAIL divu got done=%b Hi:Lo=%h want done=1 000000020000000E", dn, {Hi, Lo}); end
   endtask

   task automatic test_divzero();
      int bc; logic dn;
      do_op(DIVU, 32'h00000064, 32'h00000000, bc, dn);
      checks++; if (bc !== 33) begin errors++; $display("FAIL dbz_busy got %0d want 33", bc); end
      checks++; if ({dn, DivByZero} !== 2'b11) begin errors++; $display("FAIL dbz_flag got done,dbz=%b want 11", {dn, DivByZero}); end
      checks++; if ({Hi, Lo} !== 64'h00000064_FFFFFFFF) begin errors++; $display("FAIL dbz_divu got Hi:Lo=%h want 00000064FFFFFFFF", {Hi, Lo}); end
      repeat (3) @(posedge Clock);
      #1;
      checks++; if (DivByZero !== 1'b1) begin errors++; $display("FAIL dbz_hold got %b want 1", DivByZero); end
      Start = 1'b1; Op = MULTU; A = 32'd2; B = 32'd3;
      @(posedge Clock); #1;
      Start = 1'b0;
      checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL dbz_clear got %b want 0", DivByZero); end
      repeat (40) @(posedge Clock);
      #1;
      do_op(DIV, 32'hFFFFFFF9, 32'h00000000, bc, dn);
      checks++; if ({DivByZero, Hi, Lo} !== {1'b1, 64'hFFFFFFF9_FFFFFFFF}) begin errors++; $display("FAIL dbz_div got dbz=%b Hi:Lo=%h want dbz=1 FFFFFFF9FFFFFFFF", DivByZero, {Hi, Lo}); end
   endtask

   task automatic test_ignore_and_writes();
      int bc;
      Start = 1'b1; Op = DIVU; A = 32'd100; B = 32'd3;
      @(posedge Clock); #1;
      Start = 1'b0;
      repeat (4) @(posedge Clock);
      #1;
      Start = 1'b1; Op = MULTU; A = 32'd7; B = 32'd9;
      WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'hDEADBEEF;
      @(posedge Clock); #1;
      Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
      checks++; if ({Hi, Lo} !== 64'hFFFFFFF9_FFFFFFFF) begin errors++; $display("FAIL busy_write got Hi:Lo=%h want FFFFFFF9FFFFFFFF", {Hi, Lo}); end
      bc = 0;
      while (Done !== 1'b1 && bc < 100) begin bc++; @(posedge Clock); #1; end
      checks++; if (bc >= 100) begin errors++; $display("FAIL ignore_timeout got %0d cycles want < 100", bc); end
      checks++; if ({Hi, Lo} !== 64'h00000001_00000021) begin errors++; $display("FAIL ignore_res got Hi:Lo=%h want 0000000100000021", {Hi, Lo}); end
      @(posedge Clock); #1;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL no_queue got busy=%b want 0", Busy); end
      WriteLo = 1'b1; WriteData = 32'h00001234;
      @(posedge Clock); #1;
      WriteLo = 1'b0;
      checks++; if ({Hi, Lo} !== 64'h00000001_00001234) begin errors++; $display("FAIL writelo got Hi:Lo=%h want 0000000100001234", {Hi, Lo}); end
      WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'hA5A5_0F0F;
      @(posedge Clock); #1;
      WriteHi = 1'b0; WriteLo = 1'b0;
      checks++; if ({Hi, Lo} !== 64'hA5A50F0F_A5A50F0F) begin errors++; $display("FAIL writeboth got Hi:Lo=%h want A5A50F0FA5A50F0F", {Hi, Lo}); end
      Start = 1'b1; Op = MULTU; A = 32'd0; B = 32'd0; WriteHi = 1'b1; WriteData = 32'h1111_1111;
      @(posedge Clock); #1;
      Start = 1'b0; WriteHi = 1'b0;
      checks++; if ({Busy, Hi} !== {1'b1, 32'hA5A50F0F}) begin errors++; $display("FAIL start_wins got busy=%b Hi=%h want busy=1 A5A50F0F", Busy, Hi); end
      repeat (40) @(posedge Clock);
      #1;
   endtask

   task automatic test_back_to_back();
      int bc; logic dn;
      do_op(MULTU, 32'd1000, 32'd1000, bc, dn);
      checks++; if ({dn, Lo} !== {1'b1, 32'd1000000}) begin errors++; $display("FAIL b2b_first got done=%b Lo=%h want done=1 000F4240", dn, Lo); end
      do_op(DIVU, 32'd1000, 32'd33, bc, dn);
      checks++; if (bc !== 33) begin errors++; $display("FAIL b2b_busy got %0d want 33", bc); end
      checks++; if ({dn, Hi, Lo} !== {1'b1, 32'd10, 32'd30}) begin errors++; $display("FAIL b2b_second got done=%b Hi:Lo=%h want done=1 0000000A0000001E", dn, {Hi, Lo}); end
   endtask

   task automatic test_reset_mid();
      int bc; int dones; logic dn;
      Start = 1'b1; Op = MULT; A = 32'd12345; B = 32'd678;
      @(posedge Clock); #1;
      Start = 1'b0;
      repeat (9) @(posedge Clock);
      #1;
      Reset = 1'b0;
      @(posedge Clock); #1;
      Reset = 1'b1;
      checks++; if ({Busy, Done, Hi, Lo} !== 66'h0) begin errors++; $display("FAIL reset_mid got busy=%b done=%b Hi:Lo=%h want all 0", Busy, Done, {Hi, Lo}); end
      dones = 0;
      repeat (40) begin
         @(posedge Clock); #1;
         if (Done === 1'b1 || Busy === 1'b1) dones++;
      end
      checks++; if (dones !== 0) begin errors++; $display("FAIL reset_abort got %0d active cycles want 0", dones); end
      do_op(MULT, 32'd7, 32'hFFFFFFFA, bc, dn);
      checks++; if ({bc, dn, Hi, Lo} !== {32'd33, 1'b1, 64'hFFFFFFFF_FFFFFFD6}) begin errors++; $display("FAIL after_reset got busy=%0d done=%b Hi:Lo=%h want 33 1 FFFFFFFFFFFFFFD6", bc, dn, {Hi, Lo}); end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_divzero();
      test_ignore_and_writes();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
